// File: rtl/fhe_cmd_issuer.sv
// fhe_cmd_issuer: host command FIFO (host_cmd_*) issuing one command at a time to the FHE ALU (alu_*), with a WAIT timeout, a held response port (rsp_*) and an issued_cnt tally
module fhe_cmd_issuer #(
  parameter int DATA_W  = 64,
  parameter int OP_W    = 8,
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  input  logic [OP_W-1:0]   host_cmd_op,
  input  logic [DATA_W-1:0] host_cmd_data,
  output logic              alu_cmd_valid,
  output logic [OP_W-1:0]   alu_cmd_op,
  output logic [DATA_W-1:0] alu_cmd_data,
  input  logic              alu_busy,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic [15:0]       issued_cnt
);
  localparam int AW = $clog2(QDEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [OP_W+DATA_W-1:0] mem [QDEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [TW-1:0] timer;
  logic [OP_W-1:0] last_op;
  logic [DATA_W-1:0] last_data;
  logic [OP_W-1:0] head_op;
  logic [DATA_W-1:0] head_data;
  logic push, finish;
  assign host_cmd_ready = ~rst & (cnt != (AW+1)'(QDEPTH));
  assign push = host_cmd_valid & host_cmd_ready;
  assign {head_op, head_data} = mem[rp];
  assign alu_cmd_op = alu_cmd_valid ? head_op : last_op;
  assign alu_cmd_data = alu_cmd_valid ? head_data : last_data;
  assign rsp_valid = state == RESP;
  assign finish = state == WAIT && (alu_done || timer == TW'(TIMEOUT - 1));
  always_comb begin
    state_n = state;
    alu_cmd_valid = 1'b0;
    case (state)
      IDLE:    state_n = cnt != '0 ? ISSUE : IDLE;
      ISSUE: begin
        alu_cmd_valid = ~alu_busy;
        state_n = alu_busy ? ISSUE : WAIT;
      end
      WAIT:    state_n = finish ? RESP : WAIT;
      default: state_n = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {host_cmd_op, host_cmd_data};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(alu_cmd_valid);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(alu_cmd_valid);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      timer <= '0;
      issued_cnt <= '0;
      last_op <= '0;
      last_data <= '0;
      rsp_data <= '0;
      rsp_status <= '0;
    end else begin
      timer <= state == WAIT ? timer + 1'b1 : '0;
      if (alu_cmd_valid) begin
        issued_cnt <= issued_cnt + 1'b1;
        last_op <= head_op;
        last_data <= head_data;
      end
      if (finish) begin
        rsp_data <= alu_done ? alu_result : '0;
        rsp_status <= alu_done ? 2'b00 : 2'b01;
      end
    end
endmodule

// File: tb/tb_fhe_cmd_issuer.sv
// tb_fhe_cmd_issuer: directed vectors, corner sequences and random traffic against a transaction-level model
module tb_fhe_cmd_issuer;
  logic clk = 0, rst = 1;
  logic host_cmd_valid = 0, host_cmd_ready;
  logic [7:0] host_cmd_op = 0;
  logic [63:0] host_cmd_data = 0;
  logic alu_cmd_valid;
  logic [7:0] alu_cmd_op;
  logic [63:0] alu_cmd_data;
  logic alu_busy = 0, alu_done = 0;
  logic [63:0] alu_result = 0;
  logic rsp_valid, rsp_ready = 0;
  logic [63:0] rsp_data;
  logic [1:0] rsp_status;
  logic [15:0] issued_cnt;
  fhe_cmd_issuer #(.DATA_W(64), .OP_W(8), .QDEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd_op(host_cmd_op), .host_cmd_data(host_cmd_data),
    .alu_cmd_valid(alu_cmd_valid), .alu_cmd_op(alu_cmd_op), .alu_cmd_data(alu_cmd_data),
    .alu_busy(alu_busy), .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .issued_cnt(issued_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] op;
    logic [63:0] data;
    int dly;
    logic [63:0] res;
  } cmd_t;
  typedef struct {
    logic [7:0] op;
    logic [63:0] data;
    int dly;
    logic [63:0] res;
    logic [1:0] st;
    logic [63:0] exp;
  } vec_t;
  cmd_t hq[$], eq[$], cur, c;
  vec_t vt[5];
  bit act, wt, pend, nxt, stray_en, got;
  int since, issued_m, free_run, cyc, push_cyc, s_cyc, strobes;
  int host_pct, rdy_pct, busy_pct;
  logic [63:0] e_data, n_data, ld, d0;
  logic [7:0] lo;
  logic [1:0] e_st, n_st, s0;
  int passed = 0, total = 0;
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
  endfunction
  function automatic cmd_t rnd_cmd();
    cmd_t r;
    r.op = 8'($urandom);
    r.data = {$urandom, $urandom};
    r.res = {$urandom, $urandom};
    r.dly = $urandom_range(1, 18);
    if (r.dly > 16) r.dly = 17;
    return r;
  endfunction
  task automatic cycle();
    bit wt0;
    int qs0;
    @(posedge clk);
    #2;
    cyc++;
    host_cmd_valid = hq.size() > 0 && $urandom_range(99) < host_pct;
    if (hq.size() > 0) begin
      host_cmd_op = hq[0].op;
      host_cmd_data = hq[0].data;
    end
    rsp_ready = $urandom_range(99) < rdy_pct;
    alu_busy = $urandom_range(99) < busy_pct;
    alu_done = 0;
    alu_result = {$urandom, $urandom};
    if (act) begin
      since++;
      if (since == cur.dly) begin
        alu_done = 1;
        alu_result = cur.res;
        act = 0;
      end
    end else if (!wt && stray_en && $urandom_range(7) == 0) alu_done = 1;
    #1;
    wt0 = wt;
    qs0 = eq.size();
    chk("host_ready", host_cmd_ready, qs0 < 4);
    chk("issued_cnt", issued_cnt, 16'(issued_m));
    chk("rsp_valid", rsp_valid, pend);
    if (pend) begin
      chk("rsp_data", rsp_data, e_data);
      chk("rsp_status", rsp_status, e_st);
    end
    nxt = 0;
    if (wt && (alu_done || since == 16)) begin
      nxt = 1;
      n_data = alu_done ? alu_result : 64'h0;
      n_st = alu_done ? 2'b00 : 2'b01;
      wt = 0;
    end
    if (alu_cmd_valid) begin
      chk("strobe_allowed", !alu_busy && !wt0 && !pend && qs0 > 0, 1);
      if (eq.size() > 0) begin
        cur = eq.pop_front();
        chk("alu_op", alu_cmd_op, cur.op);
        chk("alu_data", alu_cmd_data, cur.data);
        lo = cur.op;
        ld = cur.data;
        act = 1;
        wt = 1;
        since = 0;
      end
      issued_m++;
      s_cyc = cyc;
    end else begin
      chk("alu_op_hold", alu_cmd_op, lo);
      chk("alu_data_hold", alu_cmd_data, ld);
    end
    if (host_cmd_valid && host_cmd_ready) begin
      eq.push_back(hq.pop_front());
      push_cyc = cyc;
    end
    free_run = (!wt0 && !pend && qs0 > 0 && !alu_busy && !alu_cmd_valid) ? free_run + 1 : 0;
    chk("issue_progress", free_run <= 1, 1);
    if (pend && rsp_ready) pend = 0;
    if (nxt) begin
      pend = 1;
      e_data = n_data;
      e_st = n_st;
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #4;
    rst = 1;
    host_cmd_valid = 0;
    alu_done = 0;
    #1;
    chk("rst_alu_valid", alu_cmd_valid, 0);
    chk("rst_alu_op", alu_cmd_op, 0);
    chk("rst_alu_data", alu_cmd_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_ready", host_cmd_ready, 0);
    hq.delete();
    eq.delete();
    act = 0;
    wt = 0;
    pend = 0;
    since = 0;
    issued_m = 0;
    free_run = 0;
    lo = 0;
    ld = 0;
    repeat (2) @(posedge clk);
    #4;
    rst = 0;
  endtask
  task automatic drain(int lim);
    host_pct = 100;
    rdy_pct = 100;
    busy_pct = 0;
    for (int k = 0; k < lim && (hq.size() > 0 || eq.size() > 0 || act || wt || pend); k++) cycle();
    chk("drain_complete", hq.size() + eq.size() + int'(act) + int'(wt) + int'(pend), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    host_pct = 100;
    rdy_pct = 100;
    busy_pct = 0;
    stray_en = 0;
    do_reset();
    vt[0] = '{8'h11, 64'h5, 3, 64'hABCD, 2'b00, 64'hABCD};
    vt[1] = '{8'hA5, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h1234_5678_9ABC_DEF0, 2'b00, 64'h1234_5678_9ABC_DEF0};
    vt[2] = '{8'h7F, 64'h0, 16, 64'hDEAD_BEEF, 2'b00, 64'hDEAD_BEEF};
    vt[3] = '{8'h33, 64'h77, 17, 64'h9999, 2'b01, 64'h0};
    vt[4] = '{8'hFF, 64'h1, 15, 64'h0, 2'b00, 64'h0};
    foreach (vt[i]) begin
      c.op = vt[i].op;
      c.data = vt[i].data;
      c.dly = vt[i].dly;
      c.res = vt[i].res;
      hq.push_back(c);
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
        cycle();
        if (rsp_valid) begin
          got = 1;
          chk("vec_data", rsp_data, vt[i].exp);
          chk("vec_status", rsp_status, vt[i].st);
          chk("vec_issue_latency", s_cyc - push_cyc, 2);
          chk("vec_rsp_latency", cyc - s_cyc, vt[i].dly > 16 ? 17 : vt[i].dly + 1);
          chk("vec_issued", issued_cnt, i + 1);
        end
      end
      chk("vec_rsp_seen", got, 1);
      repeat (3) cycle();
    end
    busy_pct = 100;
    repeat (5) begin
      c = rnd_cmd();
      c.dly = 2;
      hq.push_back(c);
    end
    repeat (8) cycle();
    chk("full_ready_low", host_cmd_ready, 0);
    chk("fifth_held", hq.size(), 1);
    drain(300);
    rdy_pct = 0;
    repeat (2) begin
      c = rnd_cmd();
      c.dly = 2;
      hq.push_back(c);
    end
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      cycle();
      got = rsp_valid;
    end
    chk("hold_rsp_seen", got, 1);
    d0 = rsp_data;
    s0 = rsp_status;
    strobes = 0;
    repeat (10) begin
      cycle();
      chk("hold_data", rsp_data, d0);
      chk("hold_status", rsp_status, s0);
      strobes += int'(alu_cmd_valid);
    end
    chk("hold_no_issue", strobes, 0);
    drain(100);
    repeat (3) begin
      c = rnd_cmd();
      c.dly = 17;
      hq.push_back(c);
    end
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      cycle();
      got = alu_cmd_valid;
    end
    chk("pre_rst_strobe", got, 1);
    repeat (3) cycle();
    do_reset();
    stray_en = 1;
    repeat (30) cycle();
    stray_en = 0;
    chk("post_rst_ready", host_cmd_ready, 1);
    host_pct = 50;
    rdy_pct = 60;
    busy_pct = 30;
    stray_en = 1;
    repeat (3000) begin
      if (hq.size() < 2) hq.push_back(rnd_cmd());
      cycle();
    end
    stray_en = 0;
    drain(300);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fhe_cmd_issuer.md
FHE_CMD_ISSUER -- requirements
Module: fhe_cmd_issuer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of command data and result words.
REQ-002 SHALL have parameter OP_W, default 8, opcode width.
REQ-003 SHALL have parameter QDEPTH, default 4 (power of two, >=2), host command queue depth.
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum WAIT cycles before abort.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port host_cmd_valid  input  1  host command offered.
REQ-008 SHALL have port host_cmd_ready  output  1  queue can accept a command.
REQ-009 SHALL have port host_cmd_op  input  OP_W  host opcode.
REQ-010 SHALL have port host_cmd_data  input  DATA_W  host operand.
REQ-011 SHALL have port alu_cmd_valid  output  1  one-cycle command strobe to the FHE ALU command/data port.
REQ-012 SHALL have port alu_cmd_op  output  OP_W  opcode to ALU.
REQ-013 SHALL have port alu_cmd_data  output  DATA_W  operand to ALU.
REQ-014 SHALL have port alu_busy  input  1  ALU state-port busy flag.
REQ-015 SHALL have port alu_done  input  1  ALU state-port completion pulse.
REQ-016 SHALL have port alu_result  input  DATA_W  ALU result, valid when alu_done=1.
REQ-017 SHALL have port rsp_valid  output  1  response available.
REQ-018 SHALL have port rsp_ready  input  1  host accepts response.
REQ-019 SHALL have port rsp_data  output  DATA_W  captured result (0 on timeout).
REQ-020 SHALL have port rsp_status  output  2  2'b00 OK, 2'b01 TIMEOUT; other codes unused.
REQ-021 SHALL have port issued_cnt  output  16  commands issued to ALU, wraps 0xFFFF->0.

Function
REQ-022 Queue: FIFO of {op,data}, QDEPTH entries; push on host_cmd_valid&host_cmd_ready; host_cmd_ready = not full.
REQ-023 Push and pop in same cycle when full SHALL be blocked (ready=0 when full); same-cycle push/pop when non-full SHALL keep count unchanged.
REQ-024 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-025 IDLE -> ISSUE when queue non-empty.
REQ-026 ISSUE: when alu_busy=0, assert alu_cmd_valid for exactly one cycle with head entry on alu_cmd_op/alu_cmd_data, pop queue, increment issued_cnt, clear timer, go WAIT; when alu_busy=1, stay ISSUE with alu_cmd_valid=0.
REQ-027 alu_cmd_op/alu_cmd_data SHALL hold last issued value outside the strobe cycle.
REQ-028 WAIT: timer increments each cycle; alu_done=1 captures alu_result into rsp_data, status OK, go RESP.
REQ-029 WAIT: if timer reaches TIMEOUT-1 with alu_done=0, rsp_data=0, status TIMEOUT, go RESP; alu_done on that same cycle SHALL win (OK).
REQ-030 alu_done outside WAIT SHALL be ignored.
REQ-031 RESP: rsp_valid=1, rsp_data/rsp_status stable until rsp_valid&rsp_ready; then IDLE.
REQ-032 Response latency from alu_done to rsp_valid SHALL be 1 cycle; issue-to-strobe latency from first queue entry in IDLE SHALL be 2 cycles minimum (IDLE, ISSUE).
REQ-033 Only one command SHALL be outstanding at the ALU at any time.

Reset
REQ-034 rst=1 SHALL asynchronously force: FSM IDLE, queue empty, timer 0, issued_cnt 0, alu_cmd_valid 0, alu_cmd_op 0, alu_cmd_data 0, rsp_valid 0, rsp_data 0, rsp_status 0, host_cmd_ready 0 while rst=1, 1 first cycle after release.
REQ-035 Reset mid-WAIT or mid-RESP SHALL discard the outstanding command and pending response; no response emitted after release.

Verification
REQ-036 Push op=0x11 data=0x5 with alu_busy=0, alu_done with result 0xABCD 3 cycles after strobe -> one alu_cmd_valid pulse, rsp_valid with rsp_data=0xABCD, status 00, issued_cnt=1.
REQ-037 Push 5 commands back-to-back, ALU stalled busy -> host_cmd_ready falls after 4 accepted, 5th accepted only after first pop; commands reach ALU in push order.
REQ-038 TIMEOUT=16, never assert alu_done -> rsp_valid 16 cycles after WAIT entry, rsp_data=0, status 01; late alu_done afterward ignored.
REQ-039 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_data/rsp_status stable, no new alu_cmd_valid until handshake.
REQ-040 Assert rst during WAIT with 2 entries queued -> all outputs at reset values, queue empty, no response after release.
REQ-041 Issue 65537 commands -> issued_cnt reads 1.
